// File: rtl/des_mode_sequencer.sv
// Mode controller in front of a single-block DES encrypt core: ECB/CBC/CFB/OFB/CTR
// pre/post XOR, chaining/counter register, one block in flight, core-response timeout.
module des_mode_sequencer #(
  parameter int TIMEOUT_CYC = 64,
  parameter int TMO_W       = 7
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [2:0]  mode,
  input  logic [63:0] iv,
  input  logic        iv_load,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_data,
  output logic        out_err,
  output logic [63:0] core_plain,
  output logic        core_plain_en,
  input  logic [63:0] core_cipher,
  input  logic        core_cipher_rdy,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_OUT  = 2'd2
  } state_t;

  localparam logic [2:0] M_ECB = 3'd0;
  localparam logic [2:0] M_CBC = 3'd1;
  localparam logic [2:0] M_CFB = 3'd2;
  localparam logic [2:0] M_OFB = 3'd3;
  localparam logic [2:0] M_CTR = 3'd4;

  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT_CYC);

  state_t            state_q, state_d;
  logic [63:0]       chain_q, chain_d;
  logic [63:0]       blk_q, blk_d;
  logic [2:0]        mode_q, mode_d;
  logic [63:0]       core_plain_q, core_plain_d;
  logic              core_plain_en_q, core_plain_en_d;
  logic [63:0]       out_data_q, out_data_d;
  logic              out_valid_q, out_valid_d;
  logic              out_err_q, out_err_d;
  logic [TMO_W-1:0]  tmo_q, tmo_d;

  logic accept;
  logic strobe;
  logic timeout;

  function automatic logic mode_ok(input logic [2:0] m);
    return m <= M_CTR;
  endfunction

  function automatic logic [63:0] pre_xor(input logic [2:0] m, input logic [63:0] d,
                                          input logic [63:0] c);
    case (m)
      M_ECB:   return d;
      M_CBC:   return d ^ c;
      default: return c;
    endcase
  endfunction

  function automatic logic [63:0] post_xor(input logic [2:0] m, input logic [63:0] cipher,
                                           input logic [63:0] d);
    case (m)
      M_ECB, M_CBC: return cipher;
      default:      return cipher ^ d;
    endcase
  endfunction

  function automatic logic [63:0] next_chain(input logic [2:0] m, input logic [63:0] cipher,
                                             input logic [63:0] d, input logic [63:0] c);
    case (m)
      M_CBC:   return cipher;
      M_CFB:   return cipher ^ d;
      M_OFB:   return cipher;
      M_CTR:   return c + 64'd1;
      default: return c;
    endcase
  endfunction

  assign in_ready = rstn && (state_q == S_IDLE) && !iv_load;
  assign accept   = in_valid && in_ready;
  // The strobe is ignored in the pulse cycle itself; it is only valid from the cycle after.
  assign strobe   = (state_q == S_WAIT) && core_cipher_rdy && !core_plain_en_q;
  assign timeout  = (state_q == S_WAIT) && !strobe && (tmo_q == TMO_LIMIT);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (accept) state_d = mode_ok(mode) ? S_WAIT : S_OUT;
      S_WAIT: if (strobe || timeout) state_d = S_OUT;
      S_OUT:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    chain_d         = chain_q;
    blk_d           = blk_q;
    mode_d          = mode_q;
    core_plain_d    = core_plain_q;
    core_plain_en_d = 1'b0;
    out_data_d      = out_data_q;
    out_valid_d     = out_valid_q;
    out_err_d       = out_err_q;
    tmo_d           = tmo_q;
    case (state_q)
      S_IDLE: begin
        if (iv_load) chain_d = iv;
        if (accept) begin
          blk_d  = in_data;
          mode_d = mode;
          tmo_d  = '0;
          if (mode_ok(mode)) begin
            core_plain_d    = pre_xor(mode, in_data, chain_q);
            core_plain_en_d = 1'b1;
          end else begin
            out_valid_d = 1'b1;
            out_err_d   = 1'b1;
            out_data_d  = '0;
          end
        end
      end
      S_WAIT: begin
        tmo_d = tmo_q + TMO_W'(1);
        if (strobe) begin
          out_data_d  = post_xor(mode_q, core_cipher, blk_q);
          chain_d     = next_chain(mode_q, core_cipher, blk_q, chain_q);
          out_valid_d = 1'b1;
          out_err_d   = 1'b0;
        end else if (timeout) begin
          out_data_d  = '0;
          out_valid_d = 1'b1;
          out_err_d   = 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) out_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      chain_q         <= '0;
      core_plain_q    <= '0;
      core_plain_en_q <= 1'b0;
      out_data_q      <= '0;
      out_valid_q     <= 1'b0;
      out_err_q       <= 1'b0;
      tmo_q           <= '0;
    end else begin
      chain_q         <= chain_d;
      core_plain_q    <= core_plain_d;
      core_plain_en_q <= core_plain_en_d;
      out_data_q      <= out_data_d;
      out_valid_q     <= out_valid_d;
      out_err_q       <= out_err_d;
      tmo_q           <= tmo_d;
    end
  end

  // Captured block and mode are pure data; they are always written before use.
  always_ff @(posedge clk) begin
    blk_q  <= blk_d;
    mode_q <= mode_d;
  end

  assign core_plain    = core_plain_q;
  assign core_plain_en = core_plain_en_q;
  assign out_data      = out_data_q;
  assign out_valid     = out_valid_q;
  assign out_err       = out_err_q;
  assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_des_mode_sequencer.sv
// Scoreboard bench for des_mode_sequencer: driver pushes model predictions, a monitor
// pops them on each output, and a core stub checks core_plain and returns results.
module tb_des_mode_sequencer;

  localparam int TMO = 64;
  localparam logic [63:0] KAT_P = 64'h0123456789ABCDEF;
  localparam logic [63:0] KAT_C = 64'h85E813540F0AB405;
  localparam logic [63:0] STUB_K = {8{8'hA5}};

  logic        clk, rstn;
  logic [2:0]  mode;
  logic [63:0] iv;
  logic        iv_load, in_valid, in_ready;
  logic [63:0] in_data;
  logic        out_valid, out_ready;
  logic [63:0] out_data;
  logic        out_err;
  logic [63:0] core_plain;
  logic        core_plain_en;
  logic [63:0] core_cipher;
  logic        core_cipher_rdy, busy;

  des_mode_sequencer #(.TIMEOUT_CYC(TMO), .TMO_W(7)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .iv(iv), .iv_load(iv_load),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_err(out_err),
    .core_plain(core_plain), .core_plain_en(core_plain_en),
    .core_cipher(core_cipher), .core_cipher_rdy(core_cipher_rdy), .busy(busy)
  );

  typedef struct {
    logic [63:0] data;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  typedef struct {
    logic [63:0] cp;
    int          lat;
  } core_exp_t;

  exp_t        exp_q[$];
  core_exp_t   cp_q[$];
  logic [63:0] chain_m;
  int          n_tests, n_fail, n_core, n_pulse;
  int          cyc;
  bit          hold_low, spur_en;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input bit ok, input string nm, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
    end
  endtask

  function automatic logic [63:0] core_f(input logic [63:0] p);
    return (p == KAT_P) ? KAT_C : (p ^ STUB_K);
  endfunction

  // Reference model: mode rules applied to a chain variable, outcome fixed at issue time.
  task automatic issue(input logic [2:0] m, input logic [63:0] d, input int lat);
    exp_t        e;
    core_exp_t   s;
    logic [63:0] cp, c;
    e.acc = cyc;
    if (m > 3'd4) begin
      e.data = '0; e.err = 1'b1; e.lat = 1;
    end else begin
      case (m)
        3'd0:    cp = d;
        3'd1:    cp = d ^ chain_m;
        default: cp = chain_m;
      endcase
      s.cp = cp; s.lat = lat;
      cp_q.push_back(s);
      n_core++;
      if (lat < 1 || lat > TMO) begin
        e.data = '0; e.err = 1'b1; e.lat = TMO + 2;
      end else begin
        c = core_f(cp);
        e.err = 1'b0;
        e.lat = lat + 2;
        e.data = (m <= 3'd1) ? c : (c ^ d);
        case (m)
          3'd1: chain_m = c;
          3'd2: chain_m = c ^ d;
          3'd3: chain_m = c;
          3'd4: chain_m = chain_m + 64'd1;
          default: ;
        endcase
      end
    end
    exp_q.push_back(e);
  endtask

  // Called at #1 after an edge; returns at #1 of the cycle after acceptance.
  task automatic send_block(input logic [2:0] m, input logic [63:0] d, input int lat,
                            input bit do_iv, input logic [63:0] ivv);
    int n;
    bit done;
    if (do_iv) begin
      n = 0;
      while (busy && n < 300) begin @(posedge clk); #1; n++; end
      if (n >= 300) chk(1'b0, "idle_wait_bound", 64'(n), 64'd300);
      iv_load = 1'b1;
      iv = ivv;
    end
    in_valid = 1'b1; in_data = d; mode = m;
    if (do_iv) begin
      #1;
      chk(in_ready == 1'b0, "iv_load_blocks_in_ready", 64'(in_ready), 64'd0);
      chain_m = ivv;
      @(posedge clk); #1;
      iv_load = 1'b0;
      iv = {$urandom, $urandom};
    end
    done = 1'b0; n = 0;
    while (!done) begin
      #1;
      if (in_ready) begin done = 1'b1; issue(m, d, lat); end
      @(posedge clk); #1;
      if (!done) begin
        n++;
        if (n > 500) begin chk(1'b0, "accept_bound", 64'(n), 64'd500); done = 1'b1; end
      end
    end
    in_valid = 1'b0;
    in_data = {$urandom, $urandom};
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 400) begin @(posedge clk); #1; n++; end
    if (n >= 400) chk(1'b0, "drain_bound", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic reset_checks();
    chk(out_valid == 1'b0, "rst_out_valid", 64'(out_valid), 64'd0);
    chk(out_data == 64'd0, "rst_out_data", out_data, 64'd0);
    chk(out_err == 1'b0, "rst_out_err", 64'(out_err), 64'd0);
    chk(core_plain == 64'd0, "rst_core_plain", core_plain, 64'd0);
    chk(core_plain_en == 1'b0, "rst_core_plain_en", 64'(core_plain_en), 64'd0);
    chk(busy == 1'b0, "rst_busy", 64'(busy), 64'd0);
    chk(in_ready == 1'b0, "rst_in_ready", 64'(in_ready), 64'd0);
  endtask

  // Core stub: result after a per-block latency, optional spurious strobes outside WAIT.
  initial begin
    core_exp_t   s;
    bit          pend;
    int          due;
    logic [63:0] pval, pcp;
    core_cipher_rdy = 1'b0; core_cipher = '0; pend = 1'b0; due = 0; pval = '0; pcp = '0;
    forever begin
      @(posedge clk); #1;
      core_cipher_rdy = 1'b0;
      if (pend && busy && !out_valid && !core_plain_en)
        chk(core_plain == pcp, "core_plain_stable", core_plain, pcp);
      if (core_plain_en) begin
        n_pulse++;
        if (cp_q.size() == 0) begin
          chk(1'b0, "unexpected_pulse", core_plain, 64'd0);
        end else begin
          s = cp_q.pop_front();
          chk(core_plain == s.cp, "core_plain", core_plain, s.cp);
          pcp = core_plain;
          pend = (s.lat >= 0);
          due = cyc + s.lat;
          pval = core_f(core_plain);
        end
      end
      if (pend && cyc == due) begin
        core_cipher_rdy = 1'b1; core_cipher = pval; pend = 1'b0;
      end else if (spur_en && !(busy && !out_valid) && $urandom_range(0, 7) == 0) begin
        core_cipher_rdy = 1'b1; core_cipher = {$urandom, $urandom};
      end
    end
  end

  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      out_ready = hold_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pop one prediction per output, then check it is held until taken.
  initial begin
    bit          seen;
    exp_t        e;
    logic [63:0] hold_d;
    logic        hold_e;
    seen = 1'b0; hold_d = '0; hold_e = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (!rstn) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (!seen) begin
          if (exp_q.size() == 0) begin
            chk(1'b0, "unexpected_output", out_data, 64'd0);
          end else begin
            e = exp_q.pop_front();
            chk(out_data == e.data, "out_data", out_data, e.data);
            chk(out_err == e.err, "out_err", 64'(out_err), 64'(e.err));
            chk((cyc - e.acc) == e.lat, "latency", 64'(cyc - e.acc), 64'(e.lat));
          end
          seen = 1'b1; hold_d = out_data; hold_e = out_err;
        end else begin
          chk(out_data == hold_d && out_err == hold_e, "out_stable", out_data, hold_d);
        end
        chk(in_ready == 1'b0 && busy == 1'b1, "in_ready_low_in_out", 64'(in_ready), 64'd0);
        if (out_ready) seen = 1'b0;
      end
    end
  end

  initial begin
    int n, lat, r;
    logic [2:0] m;
    n_tests = 0; n_fail = 0; n_core = 0; n_pulse = 0; cyc = 0;
    hold_low = 1'b0; spur_en = 1'b0; chain_m = '0;
    rstn = 1'b0; mode = '0; iv = '0; iv_load = 1'b0; in_valid = 1'b1; in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset_checks();
    in_valid = 1'b0;
    rstn = 1'b1;
    @(posedge clk); #1;

    // ECB known-answer vector
    send_block(3'd0, KAT_P, 10, 1'b0, '0);
    drain();
    // CBC with iv=1, two zero blocks
    send_block(3'd1, 64'd0, 16, 1'b1, 64'd1);
    send_block(3'd1, 64'd0, 16, 1'b0, '0);
    drain();
    // CTR counter wrap
    send_block(3'd4, 64'd0, 16, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF);
    send_block(3'd4, 64'd0, 16, 1'b0, '0);
    drain();
    // core never answers, then a normal block
    send_block(3'd3, {$urandom, $urandom}, -1, 1'b0, '0);
    send_block(3'd3, {$urandom, $urandom}, 5, 1'b0, '0);
    // latency boundaries
    send_block(3'd2, {$urandom, $urandom}, 1, 1'b0, '0);
    send_block(3'd2, {$urandom, $urandom}, TMO, 1'b0, '0);
    send_block(3'd0, {$urandom, $urandom}, TMO + 1, 1'b0, '0);
    send_block(3'd1, {$urandom, $urandom}, 0, 1'b0, '0);
    // unsupported mode
    send_block(3'b110, {$urandom, $urandom}, 3, 1'b0, '0);
    drain();

    // downstream stall
    hold_low = 1'b1;
    send_block(3'd0, {$urandom, $urandom}, 5, 1'b0, '0);
    n = 0;
    while (!out_valid && n < 200) begin @(posedge clk); #1; n++; end
    if (n >= 200) chk(1'b0, "out_valid_bound", 64'(n), 64'd200);
    repeat (10) @(posedge clk);
    #1;
    hold_low = 1'b0;
    drain();

    // reset while waiting on the core, then a late strobe
    send_block(3'd1, {$urandom, $urandom}, 20, 1'b1, {$urandom, $urandom});
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b0;
    @(posedge clk); #1;
    reset_checks();
    exp_q.delete();
    cp_q.delete();
    chain_m = '0;
    rstn = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      chk(out_valid == 1'b0, "no_output_after_reset", 64'(out_valid), 64'd0);
    end
    send_block(3'd3, {$urandom, $urandom}, 3, 1'b0, '0);
    drain();

    // randomized traffic
    spur_en = 1'b1;
    for (int i = 0; i < 120; i++) begin
      r = $urandom_range(0, 9);
      m = (r < 9) ? 3'(r % 5) : 3'(5 + $urandom_range(0, 2));
      r = $urandom_range(0, 19);
      case (r)
        0: lat = -1;
        1: lat = 0;
        2: lat = TMO;
        3: lat = TMO + 1;
        default: lat = $urandom_range(1, 12);
      endcase
      send_block(m, {$urandom, $urandom}, lat, ($urandom_range(0, 7) == 0), {$urandom, $urandom});
      if ($urandom_range(0, 3) == 0) begin
        iv_load = 1'b1; iv = {$urandom, $urandom};
        @(posedge clk); #1;
        iv_load = 1'b0;
      end
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain();
    spur_en = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk(n_pulse == n_core, "pulse_count", 64'(n_pulse), 64'(n_core));
    chk(exp_q.size() == 0, "scoreboard_empty", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
